// File: rtl/apb_timer_regbank.sv
// -----------------------------------------------------------------------------
// apb_timer_regbank
//
// APB3 register bank for an N-channel timer array. It sits between the APB
// interconnect and the counter cores. The cores take TDR/TCR from this bank and
// return their live TCNT plus OVF/UDF event pulses.
//
// Register map:
//   paddr[ADDR_WIDTH-1:3] selects the bank and paddr[2:0] selects the offset.
//   Channel bank c (c < NUM_CH):
//     0 TDR  RW
//     1 TCR  RW, only TCR_WMASK bits are writable
//     2 TSR  W1C, bit0 OVF, bit1 UDF
//     3 TCNT RO, passed through from the core
//     4 TIER RW, bit0 OVF-IE, bit1 UDF-IE
//   Global bank (bank == NUM_CH):
//     0 IRQ_STAT RO, bit c = irq[c]
//     1 LOCK     RW, bit0. Present only with the optional feature.
//   Any other address is invalid, and so is a write to an RO register. An
//   invalid access gives pslverr=1. An invalid read also gives prdata=0.
//
// Optional feature: define TMR_REG_LOCK_EN to add the global LOCK register.
// While LOCK=1, writes to TDR/TCR are rejected with pslverr=1.
//
// Ports:
//   pclk, preset_n      clock, asynchronous active-low reset
//   psel, penable,      APB request: select, enable, direction,
//   pwrite, paddr,      word address and write data
//   pwdata
//   prdata, pready,     registered APB response, valid while pready=1
//   pslverr
//   tmr_ovf, tmr_udf    per-channel event pulses from the counter cores
//   tcnt                live counters, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   tdr, tcr            register values to the cores, same packing as tcnt
//   irq, irq_any        registered per-channel interrupts and their OR
// -----------------------------------------------------------------------------
module apb_timer_regbank #(
  parameter int                    NUM_CH     = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [31:0]           TCR_WMASK  = 32'h0000_00B3,
  parameter logic [DATA_WIDTH-1:0] TDR_RST    = '0,
  parameter logic [DATA_WIDTH-1:0] TCR_RST    = '0
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_WIDTH-1:0]        paddr,
  input  logic [DATA_WIDTH-1:0]        pwdata,
  output logic [DATA_WIDTH-1:0]        prdata,
  output logic                         pready,
  output logic                         pslverr,
  input  logic [NUM_CH-1:0]            tmr_ovf,
  input  logic [NUM_CH-1:0]            tmr_udf,
  input  logic [NUM_CH*DATA_WIDTH-1:0] tcnt,
  output logic [NUM_CH*DATA_WIDTH-1:0] tdr,
  output logic [NUM_CH*DATA_WIDTH-1:0] tcr,
  output logic [NUM_CH-1:0]            irq,
  output logic                         irq_any
);

  localparam int                    BW    = ADDR_WIDTH - 3;
  localparam logic [DATA_WIDTH-1:0] WMASK = TCR_WMASK[DATA_WIDTH-1:0];

  localparam logic [2:0] OFF_TDR  = 3'd0;
  localparam logic [2:0] OFF_TCR  = 3'd1;
  localparam logic [2:0] OFF_TSR  = 3'd2;
  localparam logic [2:0] OFF_TCNT = 3'd3;
  localparam logic [2:0] OFF_TIER = 3'd4;
  localparam logic [2:0] OFF_IRQS = 3'd0;
  localparam logic [2:0] OFF_LOCK = 3'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] tdr_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] tdr_d  [NUM_CH];
  logic [DATA_WIDTH-1:0] tcr_q  [NUM_CH];
  logic [DATA_WIDTH-1:0] tcr_d  [NUM_CH];
  logic [1:0]            tsr_q  [NUM_CH];
  logic [1:0]            tsr_d  [NUM_CH];
  logic [1:0]            tier_q [NUM_CH];
  logic [1:0]            tier_d [NUM_CH];
  logic [1:0]            tsr_clr_s [NUM_CH];

  logic [NUM_CH-1:0]     irq_q, irq_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  lock_s;

`ifdef TMR_REG_LOCK_EN
  logic                  lock_q, lock_d;
  assign lock_s = lock_q;
`else
  assign lock_s = 1'b0;
`endif

  logic [BW-1:0]         bank_s;
  logic [2:0]            off_s;
  logic [NUM_CH-1:0]     ch_hit_s;
  logic                  is_ch_s;
  logic                  glob_hit_s;
  logic [DATA_WIDTH-1:0] cur_tdr_s, cur_tcr_s, cur_tcnt_s;
  logic [1:0]            cur_tsr_s, cur_tier_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  acc_err_s;
  logic                  commit_s;

  assign bank_s     = paddr[ADDR_WIDTH-1:3];
  assign off_s      = paddr[2:0];
  assign glob_hit_s = (bank_s == BW'(NUM_CH));
  assign is_ch_s    = |ch_hit_s;

  // Channel select: pick out the addressed channel's registers for the read mux.
  always_comb begin
    ch_hit_s   = '0;
    cur_tdr_s  = '0;
    cur_tcr_s  = '0;
    cur_tcnt_s = '0;
    cur_tsr_s  = 2'b00;
    cur_tier_s = 2'b00;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit_s[c] = (bank_s == BW'(c));
      cur_tdr_s   = ch_hit_s[c] ? tdr_q[c] : cur_tdr_s;
      cur_tcr_s   = ch_hit_s[c] ? tcr_q[c] : cur_tcr_s;
      cur_tcnt_s  = ch_hit_s[c] ? tcnt[c*DATA_WIDTH +: DATA_WIDTH] : cur_tcnt_s;
      // Include this cycle's pulses so a read sampled in WAIT sees them.
      cur_tsr_s   = ch_hit_s[c] ? (tsr_q[c] | {tmr_udf[c], tmr_ovf[c]}) : cur_tsr_s;
      cur_tier_s  = ch_hit_s[c] ? tier_q[c] : cur_tier_s;
    end
  end

  // Address decode: read data and access-error flag for the current address.
  always_comb begin
    rd_data_s = '0;
    acc_err_s = 1'b1;
    if (is_ch_s) begin
      case (off_s)
        OFF_TDR: begin
          rd_data_s = cur_tdr_s;
          acc_err_s = pwrite & lock_s;
        end
        OFF_TCR: begin
          rd_data_s = cur_tcr_s;
          acc_err_s = pwrite & lock_s;
        end
        OFF_TSR: begin
          rd_data_s = DATA_WIDTH'(cur_tsr_s);
          acc_err_s = 1'b0;
        end
        OFF_TCNT: begin
          rd_data_s = cur_tcnt_s;
          acc_err_s = pwrite;
        end
        OFF_TIER: begin
          rd_data_s = DATA_WIDTH'(cur_tier_s);
          acc_err_s = 1'b0;
        end
        default: begin
          rd_data_s = '0;
          acc_err_s = 1'b1;
        end
      endcase
    end else if (glob_hit_s) begin
      case (off_s)
        OFF_IRQS: begin
          rd_data_s = DATA_WIDTH'(irq_q);
          acc_err_s = pwrite;
        end
`ifdef TMR_REG_LOCK_EN
        OFF_LOCK: begin
          rd_data_s = DATA_WIDTH'(lock_q);
          acc_err_s = 1'b0;
        end
`endif
        default: begin
          rd_data_s = '0;
          acc_err_s = 1'b1;
        end
      endcase
    end else begin
      rd_data_s = '0;
      acc_err_s = 1'b1;
    end
  end

  // A write lands on the edge that ends RESP, and only if the address is legal.
  assign commit_s = (state_q == S_RESP) & pwrite & ~acc_err_s;

  // Handshake FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) state_d = S_SETUP;
        else                  state_d = S_IDLE;
      end
      S_SETUP: begin
        if (!psel)        state_d = S_IDLE;
        else if (penable) state_d = S_WAIT;
        else              state_d = S_SETUP;
      end
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Response next state: sampled on the WAIT->RESP edge, so it is valid only in RESP.
  always_comb begin
    pready_d  = (state_q == S_WAIT);
    pslverr_d = (state_q == S_WAIT) ? acc_err_s : 1'b0;
    if ((state_q == S_WAIT) && !pwrite) begin
      prdata_d = acc_err_s ? '0 : rd_data_s;
    end else begin
      prdata_d = prdata_q;
    end
  end

  // Per-channel register next state, W1C status and interrupt.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tdr_d[c]     = tdr_q[c];
      tcr_d[c]     = tcr_q[c];
      tier_d[c]    = tier_q[c];
      tsr_clr_s[c] = 2'b00;
      if (commit_s && ch_hit_s[c]) begin
        case (off_s)
          OFF_TDR:  tdr_d[c]     = pwdata;
          OFF_TCR:  tcr_d[c]     = (tcr_q[c] & ~WMASK) | (pwdata & WMASK);
          OFF_TSR:  tsr_clr_s[c] = pwdata[1:0];
          OFF_TIER: tier_d[c]    = pwdata[1:0];
          default:  tdr_d[c]     = tdr_q[c];
        endcase
      end else begin
        tsr_clr_s[c] = 2'b00;
      end
      // The hardware set is ORed in after the clear, so it wins a collision.
      tsr_d[c] = (tsr_q[c] & ~tsr_clr_s[c]) | {tmr_udf[c], tmr_ovf[c]};
      irq_d[c] = |(tsr_q[c] & tier_q[c]);
    end
  end

`ifdef TMR_REG_LOCK_EN
  // LOCK next state: a write to the global LOCK register.
  always_comb begin
    if (commit_s && glob_hit_s && (off_s == OFF_LOCK)) begin
      lock_d = pwdata[0];
    end else begin
      lock_d = lock_q;
    end
  end

  // LOCK register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) lock_q <= 1'b0;
    else           lock_q <= lock_d;
  end
`endif

  // FSM state and APB response registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= S_IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Channel register storage and interrupts.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tdr_q[c]  <= TDR_RST;
        tcr_q[c]  <= TCR_RST & WMASK;
        tsr_q[c]  <= 2'b00;
        tier_q[c] <= 2'b00;
      end
      irq_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        tdr_q[c]  <= tdr_d[c];
        tcr_q[c]  <= tcr_d[c];
        tsr_q[c]  <= tsr_d[c];
        tier_q[c] <= tier_d[c];
      end
      irq_q <= irq_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_pack
      assign tdr[g*DATA_WIDTH +: DATA_WIDTH] = tdr_q[g];
      assign tcr[g*DATA_WIDTH +: DATA_WIDTH] = tcr_q[g];
    end
  endgenerate

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign irq     = irq_q;
  assign irq_any = |irq_q;

endmodule

// File: tb/tb_apb_timer_regbank.sv
// Self-checking bench for apb_timer_regbank at default parameters
// (4 channels, 8-bit data, 8-bit address, TCR mask 8'hB3).
module tb_apb_timer_regbank;
  localparam int NCH = 4;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [3:0]  tmr_ovf, tmr_udf, irq;
  logic [31:0] tcnt, tdr, tcr;
  logic        irq_any;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [7:0] m_tdr [NCH];
  logic [7:0] m_tcr [NCH];
  logic [1:0] m_tsr [NCH];
  logic [1:0] m_tier[NCH];
  logic       m_lock;

  apb_timer_regbank dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tmr_ovf(tmr_ovf), .tmr_udf(tmr_udf),
    .tcnt(tcnt), .tdr(tdr), .tcr(tcr), .irq(irq), .irq_any(irq_any)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_irq();
    logic [3:0] v = 4'h0;
    for (int c = 0; c < NCH; c++) v[c] = |(m_tsr[c] & m_tier[c]);
    return v;
  endfunction

  function automatic logic [31:0] model_tdr_bus();
    logic [31:0] v = 32'h0;
    for (int c = 0; c < NCH; c++) v[c*8 +: 8] = m_tdr[c];
    return v;
  endfunction

  function automatic logic [31:0] model_tcr_bus();
    logic [31:0] v = 32'h0;
    for (int c = 0; c < NCH; c++) v[c*8 +: 8] = m_tcr[c];
    return v;
  endfunction

  function automatic void model_read(input logic [7:0] a, output logic [7:0] d,
                                     output logic e);
    int b = int'(a) / 8;
    int o = int'(a) % 8;
    d = 8'h00;
    e = 1'b1;
    if (b < NCH) begin
      e = 1'b0;
      case (o)
        0: d = m_tdr[b];
        1: d = m_tcr[b];
        2: d = {6'b0, m_tsr[b]};
        3: d = tcnt[b*8 +: 8];
        4: d = {6'b0, m_tier[b]};
        default: e = 1'b1;
      endcase
    end else if (b == NCH && o == 0) begin
      d = {4'b0, model_irq()};
      e = 1'b0;
    end else if (b == NCH && o == 1) begin
`ifdef TMR_REG_LOCK_EN
      d = {7'b0, m_lock};
      e = 1'b0;
`endif
    end
    if (e) d = 8'h00;
  endfunction

  function automatic logic model_write(input logic [7:0] a, input logic [7:0] d);
    int b = int'(a) / 8;
    int o = int'(a) % 8;
    logic e = 1'b1;
    if (b < NCH) begin
      case (o)
        0: if (!m_lock) begin m_tdr[b] = d; e = 1'b0; end
        1: if (!m_lock) begin m_tcr[b] = d & 8'hB3; e = 1'b0; end
        2: begin m_tsr[b] = m_tsr[b] & ~d[1:0]; e = 1'b0; end
        4: begin m_tier[b] = d[1:0]; e = 1'b0; end
        default: e = 1'b1;
      endcase
    end else if (b == NCH && o == 1) begin
`ifdef TMR_REG_LOCK_EN
      m_lock = d[0];
      e = 1'b0;
`endif
    end
    return e;
  endfunction

  // ---------------- bus driver ----------------
  // Runs one APB transfer. udf_resp is driven on tmr_udf during the RESP cycle.
  // waits counts the cycles from the first enable cycle until pready is seen.
  // tail is the value of pready one cycle after the response.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input logic [3:0] udf_resp, output logic [7:0] rd,
                          output logic err, output int waits, output logic tail);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready !== 1'b1 && waits < 8) begin
      @(posedge pclk); #1;
      waits++;
    end
    rd = prdata;
    err = pslverr;
    tmr_udf = udf_resp;
    @(posedge pclk); #1;
    tail = pready;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; tmr_udf = 4'h0;
  endtask

  task automatic pulse(input logic [3:0] ovf, input logic [3:0] udf);
    @(posedge pclk); #1;
    tmr_ovf = ovf; tmr_udf = udf;
    @(posedge pclk); #1;
    tmr_ovf = 4'h0; tmr_udf = 4'h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd, exp_d;
    logic err, exp_e, tail;
    int w;
    preset_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    tmr_ovf = 4'h0; tmr_udf = 4'h0; tcnt = 32'hA1B2C3D4;
    for (int c = 0; c < NCH; c++) begin
      m_tdr[c] = 8'h00; m_tcr[c] = 8'h00; m_tsr[c] = 2'b00; m_tier[c] = 2'b00;
    end
    m_lock = 1'b0;
    #22;
    checks++;
    if ({pready, pslverr, prdata, irq, irq_any} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got pready=%b pslverr=%b prdata=%h irq=%h irq_any=%b, want all 0",
               pready, pslverr, prdata, irq, irq_any);
    end
    checks++;
    if (tdr !== 32'h0 || tcr !== 32'h0) begin
      errors++;
      $display("FAIL reset_tdr_tcr: got tdr=%h tcr=%h, want 0", tdr, tcr);
    end
    preset_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      for (int o = 0; o < 5; o++) begin
        if (o == 3) continue;
        apb_xfer(1'b0, 8'(c * 8 + o), 8'h00, 4'h0, rd, err, w, tail);
        model_read(8'(c * 8 + o), exp_d, exp_e);
        checks++;
        if (rd !== exp_d || err !== exp_e) begin
          errors++;
          $display("FAIL reset_read ch%0d off%0d: got %h/%b, want %h/%b", c, o, rd, err, exp_d, exp_e);
        end
        if (c == 0 && o == 0) begin
          checks++;
          if (w !== 2 || tail !== 1'b0) begin
            errors++;
            $display("FAIL handshake_timing: got waits=%0d tail_pready=%b, want 2 and 0", w, tail);
          end
        end
      end
    end
  endtask

  task automatic test_tdr_tcr();
    logic [7:0] rd;
    logic err, tail;
    int w;
    apb_xfer(1'b1, 8'h11, 8'hFF, 4'h0, rd, err, w, tail);
    void'(model_write(8'h11, 8'hFF));
    apb_xfer(1'b0, 8'h11, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'hB3 || err !== 1'b0 || tcr !== model_tcr_bus()) begin
      errors++;
      $display("FAIL tcr_mask: got rd=%h err=%b tcr=%h, want B3/0 tcr=%h", rd, err, tcr, model_tcr_bus());
    end
    apb_xfer(1'b1, 8'h10, 8'h5A, 4'h0, rd, err, w, tail);
    void'(model_write(8'h10, 8'h5A));
    checks++;
    if (tdr !== 32'h005A_0000 || err !== 1'b0) begin
      errors++;
      $display("FAIL tdr_write: got tdr=%h err=%b, want 005a0000/0", tdr, err);
    end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    logic err, tail;
    int w;
    apb_xfer(1'b1, 8'h0C, 8'h01, 4'h0, rd, err, w, tail);
    void'(model_write(8'h0C, 8'h01));
    pulse(4'b0010, 4'b0000);
    m_tsr[1][0] = 1'b1;
    checks++;
    if (irq !== 4'h0) begin
      errors++;
      $display("FAIL irq_lag: got irq=%h one cycle after the flag, want 0", irq);
    end
    @(posedge pclk); #1;
    checks++;
    if (irq !== model_irq() || irq_any !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: got irq=%h any=%b, want %h/1", irq, irq_any, model_irq());
    end
    apb_xfer(1'b0, 8'h0A, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h01) begin
      errors++;
      $display("FAIL tsr1_read: got %h, want 01", rd);
    end
    apb_xfer(1'b0, 8'h20, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h02 || err !== 1'b0) begin
      errors++;
      $display("FAIL irq_stat: got %h/%b, want 02/0", rd, err);
    end
    apb_xfer(1'b1, 8'h0A, 8'h01, 4'h0, rd, err, w, tail);
    void'(model_write(8'h0A, 8'h01));
    @(posedge pclk); #1;
    checks++;
    if (irq !== 4'h0 || irq_any !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got irq=%h any=%b, want 0/0", irq, irq_any);
    end
    apb_xfer(1'b0, 8'h0A, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL tsr1_w1c: got %h, want 00", rd);
    end
  endtask

  task automatic test_collision();
    logic [7:0] rd;
    logic err, tail;
    int w;
    pulse(4'b0000, 4'b0001);
    m_tsr[0][1] = 1'b1;
    apb_xfer(1'b1, 8'h02, 8'h02, 4'b0001, rd, err, w, tail);
    void'(model_write(8'h02, 8'h02));
    m_tsr[0][1] = 1'b1;
    apb_xfer(1'b0, 8'h02, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h02) begin
      errors++;
      $display("FAIL set_beats_clear: got tsr0=%h, want 02", rd);
    end
    apb_xfer(1'b1, 8'h02, 8'h02, 4'h0, rd, err, w, tail);
    void'(model_write(8'h02, 8'h02));
    apb_xfer(1'b0, 8'h02, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h00) begin
      errors++;
      $display("FAIL tsr0_clear: got %h, want 00", rd);
    end
  endtask

  task automatic test_errors();
    logic [7:0] rd;
    logic err, tail;
    int w;
    apb_xfer(1'b0, 8'h28, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h00 || err !== 1'b1) begin
      errors++;
      $display("FAIL bad_bank_read: got %h/%b, want 00/1", rd, err);
    end
    apb_xfer(1'b1, 8'h03, 8'h77, 4'h0, rd, err, w, tail);
    checks++;
    if (err !== 1'b1 || tdr !== model_tdr_bus() || tcr !== model_tcr_bus()) begin
      errors++;
      $display("FAIL tcnt_write: got err=%b tdr=%h tcr=%h, want 1 %h %h", err, tdr, tcr,
               model_tdr_bus(), model_tcr_bus());
    end
    apb_xfer(1'b0, 8'h03, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== tcnt[7:0] || err !== 1'b0) begin
      errors++;
      $display("FAIL tcnt_read: got %h/%b, want %h/0", rd, err, tcnt[7:0]);
    end
    apb_xfer(1'b0, 8'h15, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h00 || err !== 1'b1) begin
      errors++;
      $display("FAIL bad_offset_read: got %h/%b, want 00/1", rd, err);
    end
    apb_xfer(1'b1, 8'h20, 8'hFF, 4'h0, rd, err, w, tail);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL irq_stat_write: got err=%b, want 1", err);
    end
`ifndef TMR_REG_LOCK_EN
    apb_xfer(1'b1, 8'h21, 8'h01, 4'h0, rd, err, w, tail);
    apb_xfer(1'b0, 8'h21, 8'h00, 4'h0, rd, err, w, tail);
    checks++;
    if (rd !== 8'h00 || err !== 1'b1) begin
      errors++;
      $display("FAIL no_lock_reg: got %h/%b, want 00/1", rd, err);
    end
`endif
  endtask

  task automatic test_psel_drop();
    int seen = 0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hEE;
    @(posedge pclk); #1;
    psel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pready === 1'b1) seen++;
      @(posedge pclk); #1;
    end
    pwrite = 1'b0;
    checks++;
    if (seen != 0 || tdr !== model_tdr_bus()) begin
      errors++;
      $display("FAIL psel_drop: got pready cycles=%0d tdr=%h, want 0 and %h", seen, tdr, model_tdr_bus());
    end
  endtask

`ifdef TMR_REG_LOCK_EN
  task automatic test_lock();
    logic [7:0] rd;
    logic err, tail;
    int w;
    apb_xfer(1'b1, 8'h21, 8'h01, 4'h0, rd, err, w, tail);
    void'(model_write(8'h21, 8'h01));
    apb_xfer(1'b1, 8'h00, 8'h11, 4'h0, rd, err, w, tail);
    checks++;
    if (err !== 1'b1 || tdr !== model_tdr_bus()) begin
      errors++;
      $display("FAIL locked_write: got err=%b tdr=%h, want 1 %h", err, tdr, model_tdr_bus());
    end
    apb_xfer(1'b1, 8'h04, 8'h03, 4'h0, rd, err, w, tail);
    void'(model_write(8'h04, 8'h03));
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL locked_tier: got err=%b, want 0", err);
    end
    apb_xfer(1'b1, 8'h21, 8'h00, 4'h0, rd, err, w, tail);
    void'(model_write(8'h21, 8'h00));
    apb_xfer(1'b1, 8'h00, 8'h11, 4'h0, rd, err, w, tail);
    void'(model_write(8'h00, 8'h11));
    checks++;
    if (err !== 1'b0 || tdr[7:0] !== 8'h11) begin
      errors++;
      $display("FAIL unlocked_write: got err=%b tdr0=%h, want 0/11", err, tdr[7:0]);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] rd, a, wd, exp_d;
    logic err, exp_e, wr, tail;
    int w;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [3:0] ov = 4'($urandom_range(0, 15));
        logic [3:0] ud = 4'($urandom_range(0, 15));
        pulse(ov, ud);
        for (int c = 0; c < NCH; c++) m_tsr[c] = m_tsr[c] | {ud[c], ov[c]};
      end
      tcnt = $urandom;
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 47));
      wd = 8'($urandom_range(0, 255));
      if (wr) begin
        exp_e = model_write(a, wd);
        apb_xfer(1'b1, a, wd, 4'h0, rd, err, w, tail);
        exp_d = rd;
      end else begin
        model_read(a, exp_d, exp_e);
        apb_xfer(1'b0, a, 8'h00, 4'h0, rd, err, w, tail);
      end
      @(posedge pclk); #1;
      checks++;
      if (err !== exp_e || rd !== exp_d || w !== 2 || tdr !== model_tdr_bus() ||
          tcr !== model_tcr_bus() || irq !== model_irq()) begin
        errors++;
        $display("FAIL random[%0d] %s a=%h: got rd=%h err=%b waits=%0d tdr=%h tcr=%h irq=%h, want rd=%h err=%b waits=2 tdr=%h tcr=%h irq=%h",
                 i, wr ? "wr" : "rd", a, rd, err, w, tdr, tcr, irq, exp_d, exp_e,
                 model_tdr_bus(), model_tcr_bus(), model_irq());
      end
    end
  endtask

  initial begin
    test_reset();
    test_tdr_tcr();
    test_irq();
    test_collision();
    test_errors();
    test_psel_drop();
`ifdef TMR_REG_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_timer_regbank.md
Name: apb_timer_regbank

Overview:
- Parametrised APB3 register bank for an N-channel timer array.
- Per channel it holds a data register (TDR), a control register (TCR), a W1C sticky status register (TSR) and an interrupt-enable register (TIER); it also exposes a live counter (TCNT) for reads.
- Adds one fixed wait state, combined per-channel interrupts, and global summary registers.
- Sits between the APB interconnect and the counter cores: the cores consume TDR/TCR and return TCNT plus OVF/UDF pulses.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- DATA_WIDTH, 8, register and PWDATA/PRDATA width (8..32).
- ADDR_WIDTH, 8, PADDR width; must be >= clog2(NUM_CH+1)+3.
- TCR_WMASK, 8'hB3, writable-bit mask for TCR (zero-extended to DATA_WIDTH).
- TDR_RST, 0, reset value of every TDR.
- TCR_RST, 0, reset value of every TCR.

Ports:
- pclk  in  1  APB clock
- preset_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_WIDTH  byte-free word address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, valid when pready=1
- pready  out  1  transfer complete
- pslverr  out  1  error, valid when pready=1
- tmr_ovf  in  NUM_CH  per-channel overflow pulse
- tmr_udf  in  NUM_CH  per-channel underflow pulse
- tcnt  in  NUM_CH*DATA_WIDTH  live counters, channel c at [c*DW +: DW]
- tdr  out  NUM_CH*DATA_WIDTH  TDR values, same packing
- tcr  out  NUM_CH*DATA_WIDTH  TCR values, same packing
- irq  out  NUM_CH  per-channel interrupt, registered
- irq_any  out  1  OR of irq

Behaviour:
- Address decode: paddr[ADDR_WIDTH-1:3] selects the bank (c < NUM_CH is a channel; c == NUM_CH is the global bank); paddr[2:0] selects the offset.
- Channel offsets: 0 = TDR (RW), 1 = TCR (RW, masked by TCR_WMASK), 2 = TSR (W1C; bit0 OVF, bit1 UDF; other bits read 0), 3 = TCNT (RO), 4 = TIER (RW; bit0 OVF-IE, bit1 UDF-IE).
- Global offsets: 0 = IRQ_STAT (RO; bit c = irq[c]), 1 = LOCK (only with the optional feature).
- Any other address is invalid. A write to an RO register is invalid.
- Handshake FSM, states IDLE, SETUP, WAIT, RESP:
  - IDLE→SETUP on psel & !penable.
  - SETUP→WAIT on psel & penable.
  - SETUP→IDLE on !psel.
  - WAIT→RESP unconditionally.
  - RESP→IDLE.
- pready is registered and is high only in RESP: exactly one wait cycle, and pready is high for exactly one cycle per transfer.
- prdata and pslverr are registered and valid in RESP.
- prdata holds its last value outside RESP. For an invalid read, prdata is 0 and pslverr is 1.
- Write commit: registers update on the rising edge that ends RESP, i.e. when the FSM is in RESP with pwrite=1 and the address is valid. An invalid write changes nothing and sets pslverr.
- Read sampling: data is sampled at the WAIT→RESP edge, so a TSR read reflects flags set up to and including the WAIT cycle.
- TSR flags: a tmr_ovf/tmr_udf pulse sets the flag; it stays sticky until a write of 1 clears it.
- A hardware set and a W1C clear in the same cycle: the set wins and the flag stays 1.
- irq[c] is registered: it is (TSR.OVF & TIER.OVF) | (TSR.UDF & TIER.UDF) from the previous cycle, so irq lags the flag by 1 cycle.
- psel dropped mid-transfer (in SETUP): return to IDLE with no response and no side effects. Once in WAIT, the transfer completes regardless of psel.
- Reset (asynchronous, any state):
  - FSM → IDLE.
  - pready, pslverr, prdata, irq, irq_any = 0.
  - TDR = TDR_RST; TCR = TCR_RST & TCR_WMASK.
  - TSR, TIER = 0.
  - LOCK = 0.

Optional Feature:
- Macro TMR_REG_LOCK_EN.
- When defined:
  - The global LOCK register at offset 1 is RW; bit0 is LOCK.
  - While LOCK=1, writes to any TDR or TCR return pslverr=1 and leave the register unchanged.
  - TSR, TIER and LOCK itself stay writable.
  - Writing 0 to LOCK bit0 unlocks.
- When not defined: global offset 1 is an invalid address (pslverr=1, prdata 0), and TDR/TCR are always writable.

Test Plan:
- Reset, then read TDR/TCR/TSR/TIER of every channel → 0; a transfer takes SETUP plus 2 access cycles; pready is a single-cycle pulse.
- Write ch2 TCR=8'hFF → readback 8'hB3; write ch2 TDR=8'h5A → tdr[23:16]=8'h5A after commit; other channels unchanged.
- Pulse tmr_ovf[1] with TIER1=1 → TSR1=8'h01 and irq[1]=1 one cycle later; IRQ_STAT=8'h02; write TSR1=8'h01 → TSR1=0 and irq[1] drops.
- Pulse tmr_udf[0] in the same cycle as a W1C write of TSR0=8'h02 → TSR0 bit1 stays 1.
- Read address {NUM_CH+1, 0} → pslverr=1, prdata=0. Write ch0 TCNT → pslverr=1 and tcnt passthrough is unaffected. Drop psel in SETUP → no pready.
- With TMR_REG_LOCK_EN: write LOCK=1, then write ch0 TDR=8'h11 → pslverr=1 and TDR unchanged. Write LOCK=0, repeat the write → TDR=8'h11.
